sar_adc_ctrl: RTL and testbench
===============================

Name: sar_adc_ctrl

Overview:
- Successive-approximation controller for the analog OTA macro, which is configured as the conversion comparator.
- Drives the trial code to the capacitive/resistor DAC feeding the OTA input (upstream side).
- Consumes the OTA's comparator decision (downstream side) and produces a WIDTH-bit result with a done pulse.
- Sits between the analog tile pins and the digital uo_out/uio path of the top-level wrapper.

Parameters:
- WIDTH, 8: result and DAC code width in bits.
- SAMPLE_CYCLES, 4: number of cycles the `sample` output stays high (track phase); must be at least 1.
- SETTLE_CYCLES, 2: wait cycles after each DAC trial update before the decision; must be at least 2 to cover the synchronizer.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- ena, input, 1: block enable; low aborts the conversion.
- start, input, 1: conversion request, level-sampled while in IDLE.
- cmp_in, input, 1: raw asynchronous OTA comparator output; 1 means Vin > Vdac.
- cont, input, 1: continuous-mode request; used only with the optional feature.
- dac_code, output, WIDTH: code driven to the DAC.
- sample, output, 1: track/hold switch control; 1 means track.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when `result` updates.
- result, output, WIDTH: last completed conversion.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State returns to IDLE.
  - dac_code=0, sample=0, busy=0, done=0, result=0.
  - Synchronizer flops and counters are cleared.
- cmp_in passes through a 2-flop synchronizer to produce cmp_s; only cmp_s is used.
- States: IDLE, SAMPLE, SETTLE, DECIDE, DONE.
- IDLE:
  - dac_code=0.
  - If start=1 and ena=1 at an edge, go to SAMPLE.
- SAMPLE:
  - sample=1 for exactly SAMPLE_CYCLES cycles, dac_code=0.
  - Then load bit index i=WIDTH-1 and go to SETTLE.
- SETTLE:
  - dac_code = accumulated decided bits OR (1<<i), presented on the first SETTLE cycle.
  - Hold for SETTLE_CYCLES cycles, then go to DECIDE.
- DECIDE (1 cycle):
  - If cmp_s=1, keep bit i; otherwise clear it.
  - If i=0, go to DONE; else decrement i and go to SETTLE.
- DONE (1 cycle):
  - done=1 and result is loaded with the final code.
  - dac_code holds the final code.
  - Next state is IDLE.
- Latency from the start-sampling edge to the cycle where done is high: SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) + 1. With defaults this is 29 cycles.
- result holds its value between DONE states and is unchanged by aborts.
- start while busy is ignored; start pulses are not queued.
- ena low in any non-IDLE state:
  - Synchronous return to IDLE on the next edge.
  - No done pulse; dac_code returns to 0.
- Reset mid-conversion: immediate return to IDLE with all outputs at their reset values, including result=0.
- Bit arithmetic: only bit i of the accumulator changes per DECIDE; no carries or overflow.
- sample and done are registered outputs; there is no combinational path from any input to any output.

Optional Feature:
- Macro: SAR_CONT_EN.
- Defined:
  - In DONE, if cont=1 and ena=1, the next state is SAMPLE instead of IDLE.
  - busy stays high across back-to-back conversions, giving one done pulse every SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) + 1 cycles.
  - Deasserting cont lets the current conversion finish, then the block returns to IDLE.
- Not defined:
  - cont is ignored and DONE always returns to IDLE.
  - Each conversion needs a new start.

Test Plan:
1. Comparator model with Vin code 0xA5 (cmp_in = Vin > dac_code); pulse start → done high exactly 29 cycles after the start edge, result=0xA5, sample high for cycles 1-4 only.
2. cmp_in tied 1 → result=0xFF; cmp_in tied 0 → result=0x00; dac_code trial sequence for the tied-0 case is 0x80,0x40,…,0x01.
3. Convert 0x3C, then re-pulse start at cycle 10 → ignored, single done pulse, result=0x3C; next start then converts a new Vin of 0xC3 → 0xC3.
4. Drop ena at cycle 15 of a conversion → IDLE next cycle, busy=0, no done, result keeps its previous 0x3C; assert rst_n=0 mid-conversion → all outputs 0 with no clock edge.
5. SAR_CONT_EN defined, cont=1, Vin stepping 0x10→0x20 → done pulses every 29 cycles with results 0x10 then 0x20; clear cont → one more result, then busy=0.

Source files
------------

// File: rtl/sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// sar_adc_ctrl
//   Successive-approximation controller for the analog OTA macro, which is
//   used as the conversion comparator. Samples the input, then walks a trial
//   code from MSB to LSB on the DAC. Each bit is kept or cleared from the
//   synchronized comparator decision.
//
// Parameters
//   WIDTH          result / DAC code width in bits
//   SAMPLE_CYCLES  cycles with `sample` high (track phase), >= 1
//   SETTLE_CYCLES  wait cycles after each DAC update, >= 2 (covers synchronizer)
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   ena       in   block enable; low aborts a conversion
//   start     in   conversion request, level-sampled in IDLE
//   cmp_in    in   raw asynchronous comparator output (1: Vin > Vdac)
//   cont      in   continuous-mode request (only with SAR_CONT_EN)
//   dac_code  out  trial code driven to the DAC
//   sample    out  track/hold switch (1: track)
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse when `result` updates
//   result    out  last completed conversion
//
// Optional feature
//   SAR_CONT_EN  when defined, DONE restarts sampling while cont=1 and ena=1.
//
// Handshake
//   start is a level request honoured only in IDLE with ena=1; it is neither
//   queued nor acknowledged. done is a single-cycle strobe qualifying result,
//   with no back-pressure. All outputs are registered.
// -----------------------------------------------------------------------------
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             cmp_in,
  input  logic             cont,
  output logic [WIDTH-1:0] dac_code,
  output logic             sample,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW      = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);
  localparam int IW      = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SAMPLE = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_DECIDE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] TOP_MASK = ONE << (WIDTH - 1);

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] acc;      // bits already decided (excludes the bit on trial)
  logic             cmp_meta;
  logic             cmp_s;

  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] decided;

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_meta <= 1'b0;
      cmp_s    <= 1'b0;
    end else begin
      cmp_meta <= cmp_in;
      cmp_s    <= cmp_meta;
    end
  end

  // Only bit idx is touched per decision, so no carry can ripple.
  always_comb begin
    bit_mask = ONE << idx;
    decided  = acc | (cmp_s ? bit_mask : '0);
  end

`ifdef SAR_CONT_EN
  logic restart;
  assign restart = cont & ena;
`else
  logic restart;
  logic unused_cont;
  assign restart     = 1'b0;
  assign unused_cont = cont;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx      <= '0;
      acc      <= '0;
      dac_code <= '0;
      sample   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else if (!ena && state != ST_IDLE) begin
      // Abort: back to IDLE, result untouched, no done pulse.
      state    <= ST_IDLE;
      cnt      <= '0;
      dac_code <= '0;
      sample   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          dac_code <= '0;
          if (start && ena) begin
            state  <= ST_SAMPLE;
            cnt    <= CW'(SAMPLE_CYCLES - 1);
            sample <= 1'b1;
            busy   <= 1'b1;
          end
        end

        ST_SAMPLE: begin
          if (cnt == '0) begin
            // Present the MSB trial on the first SETTLE cycle.
            state    <= ST_SETTLE;
            cnt      <= CW'(SETTLE_CYCLES - 1);
            idx      <= IW'(WIDTH - 1);
            acc      <= '0;
            dac_code <= TOP_MASK;
            sample   <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        ST_SETTLE: begin
          if (cnt == '0) begin
            state <= ST_DECIDE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        ST_DECIDE: begin
          if (idx == '0) begin
            state    <= ST_DONE;
            acc      <= decided;
            dac_code <= decided;
            result   <= decided;
            done     <= 1'b1;
          end else begin
            state    <= ST_SETTLE;
            cnt      <= CW'(SETTLE_CYCLES - 1);
            idx      <= idx - IW'(1);
            acc      <= decided;
            dac_code <= decided | (bit_mask >> 1);
          end
        end

        ST_DONE: begin
          dac_code <= '0;
          if (restart) begin
            state  <= ST_SAMPLE;
            cnt    <= CW'(SAMPLE_CYCLES - 1);
            sample <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= ST_IDLE;
          dac_code <= '0;
          sample   <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_adc_ctrl
//   Directed bench for sar_adc_ctrl with default parameters (8 bits, 4 sample
//   cycles, 2 settle cycles). The analog input is modelled as sitting half an
//   LSB above the integer code vin, so the comparator reports 1 whenever
//   dac_code <= vin and a correct SAR walk converges exactly on vin.
//   Expected results are queued when a conversion is launched; a monitor pops
//   one entry for every done pulse.
// -----------------------------------------------------------------------------
module tb_sar_adc_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic       cmp_in;
  logic       cont;
  logic [7:0] dac_code;
  logic       sample;
  logic       busy;
  logic       done;
  logic [7:0] result;

  logic [7:0] vin;
  logic       force_en;
  logic       force_val;

  logic [7:0] exp_q[$];
  int         checks;
  int         errors;

  sar_adc_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .start    (start),
    .cmp_in   (cmp_in),
    .cont     (cont),
    .dac_code (dac_code),
    .sample   (sample),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model: Vin = vin + 0.5 LSB.
  assign cmp_in = force_en ? force_val : (dac_code <= vin);

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result 0x%0h expected no done at %0t", result, $time);
      end else begin
        chk("sb_result", {24'd0, result}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- drivers ----------------
  // Returns just after the start-sampling edge (edge 0).
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // One conversion, checked cycle by cycle. n counts edges after edge 0;
  // outputs sampled at the negedge after edge n belong to cycle n+1.
  //   expv      expected result (or, for an abort, the result that must persist)
  //   restart_at  cycle index where start is re-pulsed while busy (-1: none)
  //   abort_at    edge where ena is seen low (-1: none)
  //   chk_seq     check the tied-0 trial sequence 0x80 >> k
  task automatic run_conv(input logic [7:0] expv, input int restart_at,
                          input int abort_at, input bit chk_seq);
    if (abort_at < 0) exp_q.push_back(expv);
    pulse_start();
    for (int n = 0; n <= 29; n++) begin
      @(negedge clk);
      if (abort_at >= 0 && n == abort_at) begin
        chk("abort_busy",   {31'd0, busy},   32'd0);
        chk("abort_sample", {31'd0, sample}, 32'd0);
        chk("abort_done",   {31'd0, done},   32'd0);
        chk("abort_dac",    {24'd0, dac_code}, 32'd0);
        chk("abort_result", {24'd0, result}, {24'd0, expv});
        break;
      end
      chk("sample", {31'd0, sample}, (n < 4) ? 32'd1 : 32'd0);
      chk("done",   {31'd0, done},   (n == 28) ? 32'd1 : 32'd0);
      chk("busy",   {31'd0, busy},   (n <= 28) ? 32'd1 : 32'd0);
      if (chk_seq && n >= 4 && n < 28 && ((n - 4) % 3) == 0)
        chk("dac_trial", {24'd0, dac_code}, {24'd0, 8'h80 >> ((n - 4) / 3)});
      if (n == 28) chk("dac_final", {24'd0, dac_code}, {24'd0, expv});
      if (n == 29) chk("dac_idle", {24'd0, dac_code}, 32'd0);
      if (n == restart_at) start = 1'b1;
      if (n == restart_at + 1) start = 1'b0;
      if (abort_at >= 0 && n == abort_at - 1) ena = 1'b0;
    end
    ena   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    start     = 1'b0;
    cont      = 1'b0;
    vin       = 8'h00;
    force_en  = 1'b0;
    force_val = 1'b0;

    #2;
    chk("rst_dac",    {24'd0, dac_code}, 32'd0);
    chk("rst_sample", {31'd0, sample},   32'd0);
    chk("rst_busy",   {31'd0, busy},     32'd0);
    chk("rst_done",   {31'd0, done},     32'd0);
    chk("rst_result", {24'd0, result},   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic conversion
    vin = 8'hA5;
    run_conv(8'hA5, -1, -1, 1'b0);

    // Comparator tied high / low
    force_en  = 1'b1;
    force_val = 1'b1;
    run_conv(8'hFF, -1, -1, 1'b0);
    force_val = 1'b0;
    run_conv(8'h00, -1, -1, 1'b1);
    force_en  = 1'b0;

    // start while busy is ignored
    vin = 8'h3C;
    run_conv(8'h3C, 10, -1, 1'b0);
    vin = 8'hC3;
`ifndef SAR_CONT_EN
    cont = 1'b1;  // ignored without the continuous-mode feature
`endif
    run_conv(8'hC3, -1, -1, 1'b0);
    cont = 1'b0;

    // Abort with ena low; result keeps the previous value
    vin = 8'h3C;
    run_conv(8'h3C, -1, -1, 1'b0);
    vin = 8'h77;
    run_conv(8'h3C, -1, 15, 1'b0);
    repeat (35) @(negedge clk);
    chk("post_abort_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-conversion
    vin = 8'h55;
    pulse_start();
    repeat (20) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_dac",    {24'd0, dac_code}, 32'd0);
    chk("mid_rst_sample", {31'd0, sample},   32'd0);
    chk("mid_rst_busy",   {31'd0, busy},     32'd0);
    chk("mid_rst_done",   {31'd0, done},     32'd0);
    chk("mid_rst_result", {24'd0, result},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (35) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

`ifdef SAR_CONT_EN
    // Back-to-back conversions: done at edges 28, 57, 86; cont cleared during
    // the third, which completes before returning to IDLE.
    cont = 1'b1;
    vin  = 8'h10;
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h30);
    pulse_start();
    for (int n = 0; n <= 87; n++) begin
      @(negedge clk);
      chk("cont_done", {31'd0, done}, (n == 28 || n == 57 || n == 86) ? 32'd1 : 32'd0);
      chk("cont_busy", {31'd0, busy}, (n <= 86) ? 32'd1 : 32'd0);
      if (n == 28) vin = 8'h20;
      if (n == 57) vin = 8'h30;
      if (n == 60) cont = 1'b0;
    end
    repeat (3) @(negedge clk);
`endif

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
